// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation is accepted in IDLE, executes for one cycle, and is held in RESP until consumed.
module alu_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       last_grant;
   logic       grant;
   logic       accept;

   // A lone requester wins; on a tie the one not served last wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   assign accept = (state == IDLE) && (req0_valid || req1_valid);

   // Ready is combinational; rst_n gating keeps both low while reset is held.
   assign req0_ready = rst_n && accept && !grant;
   assign req1_ready = rst_n && accept && grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture on accept, result capture at the end of EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_ctrl   <= 3'd0;
         rsp_id     <= 1'b0;
         last_grant <= 1'b1;
         rsp_data   <= '0;
         rsp_valid  <= 1'b0;
      end else begin
         if (accept) begin
            alu_a      <= grant ? req1_a : req0_a;
            alu_b      <= grant ? req1_b : req0_b;
            alu_ctrl   <= grant ? req1_op : req0_op;
            rsp_id     <= grant;
            last_grant <= grant;
         end
         if (state == EXEC) begin
            rsp_data  <= alu_result;
            rsp_valid <= 1'b1;
         end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of the arbitration rules.
module tb_alu_arbiter;

   localparam int unsigned W = 32;

   logic         clk;
   logic         rst_n;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]   req0_op, req1_op;
   logic [W-1:0] alu_a, alu_b, alu_result, rsp_data;
   logic [2:0]   alu_ctrl;
   logic         rsp_valid, rsp_ready, rsp_id;

   int   checks = 0;
   int   passes = 0;
   logic model_lg = 1'b1;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd3:    return a - b;
         3'd4:    return a ^ b;
         3'd5:    return a << b[4:0];
         3'd6:    return (a < b) ? W'(1) : W'(0);
         default: return ~(a | b);
      endcase
   endfunction

   // Shared ALU seen by the DUT.
   assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);

   task automatic rand_operands();
      req0_a  = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
      req1_a  = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_lg = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      rand_operands();
      #3;
      checks++;
      if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, alu_a, alu_b, alu_ctrl} !== '0) begin
         $display("FAIL reset_outputs: r0=%b r1=%b rv=%b id=%b data=%h a=%h b=%h ctrl=%h, required all 0",
                  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, alu_a, alu_b, alu_ctrl);
      end else passes++;
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready, rsp_valid, alu_a} !== '0) begin
         $display("FAIL reset_held: r0=%b r1=%b rv=%b a=%h, required 0", req0_ready, req1_ready, rsp_valid, alu_a);
      end else passes++;
      rst_n = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         $display("FAIL reset_first_tie: ready=%b%b, required 10", req0_ready, req1_ready);
      end else passes++;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({rsp_valid, req0_ready, req1_ready, alu_a} !== '0) begin
         $display("FAIL reset_withdraw: rv=%b ready=%b%b a=%h, required 0", rsp_valid, req0_ready, req1_ready, alu_a);
      end else passes++;
   endtask

   task automatic test_single();
      do_reset();
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b010; rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         $display("FAIL single_ready: ready=%b%b, required 10", req0_ready, req1_ready);
      end else passes++;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready, rsp_valid, alu_a, alu_b, alu_ctrl} !== {3'b000, 32'd5, 32'd3, 3'b010}) begin
         $display("FAIL single_exec: ready=%b%b rv=%b a=%h b=%h ctrl=%h, required 000 5 3 2",
                  req0_ready, req1_ready, rsp_valid, alu_a, alu_b, alu_ctrl);
      end else passes++;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd8}) begin
         $display("FAIL single_resp: rv=%b id=%b data=%h, required 1 0 8", rsp_valid, rsp_id, rsp_data);
      end else passes++;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({rsp_valid, alu_a, alu_ctrl} !== {1'b0, 32'd5, 3'b010}) begin
         $display("FAIL single_idle_hold: rv=%b a=%h ctrl=%h, required 0 5 2", rsp_valid, alu_a, alu_ctrl);
      end else passes++;
   endtask

   task automatic test_operand_change();
      do_reset();
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b010; rsp_ready = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      req0_a = 32'd9; req0_b = 32'd100; req0_op = 3'b111; req0_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({alu_a, alu_b, alu_ctrl} !== {32'd5, 32'd3, 3'b010}) begin
         $display("FAIL opchg_latched: a=%h b=%h ctrl=%h, required 5 3 2", alu_a, alu_b, alu_ctrl);
      end else passes++;
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_data} !== {1'b1, 32'd8}) begin
         $display("FAIL opchg_result: rv=%b data=%h, required 1 8", rsp_valid, rsp_data);
      end else passes++;
   endtask

   task automatic test_stream(input logic v0, input logic v1, input string name);
      logic         exp_g;
      logic [W-1:0] exp_d;
      bit           got;
      do_reset();
      rand_operands();
      req0_valid = v0; req1_valid = v1; rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int t = 0; t < 8 && !got; t++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) got = 1'b1;
            else begin @(posedge clk); #1; end
         end
         exp_g = (v0 && v1) ? k[0] : v1;
         exp_d = exp_g ? alu_f(req1_a, req1_b, req1_op) : alu_f(req0_a, req0_b, req0_op);
         checks++;
         if (!got || {req0_ready, req1_ready} !== (exp_g ? 2'b01 : 2'b10)) begin
            $display("FAIL %s_grant%0d: ready=%b%b got=%0d, required grant %0d", name, k,
                     req0_ready, req1_ready, got, exp_g);
         end else passes++;
         @(posedge clk); #1;
         rand_operands();
         @(negedge clk);
         @(negedge clk);
         checks++;
         if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, exp_g, exp_d}) begin
            $display("FAIL %s_resp%0d: rv=%b id=%b data=%h, required 1 %b %h", name, k,
                     rsp_valid, rsp_id, rsp_data, exp_g, exp_d);
         end else passes++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] exp_d;
      do_reset();
      rand_operands();
      req0_valid = 1'b1; rsp_ready = 1'b0;
      @(negedge clk);
      exp_d = alu_f(req0_a, req0_b, req0_op);
      @(posedge clk); #1;
      req1_valid = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         rand_operands();
         @(negedge clk);
         checks++;
         if ({rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready} !== {1'b1, 1'b0, exp_d, 2'b00}) begin
            $display("FAIL bp_hold%0d: rv=%b id=%b data=%h ready=%b%b, required 1 0 %h 00", c,
                     rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, exp_d);
         end else passes++;
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
         $display("FAIL bp_release: rv=%b ready=%b%b, required 0 01", rsp_valid, req0_ready, req1_ready);
      end else passes++;
   endtask

   task automatic test_reset_mid_exec();
      logic [W-1:0] exp_d;
      do_reset();
      rand_operands();
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, alu_a, alu_b, alu_ctrl} !== '0) begin
         $display("FAIL midreset_outputs: ready=%b%b rv=%b id=%b data=%h a=%h, required all 0",
                  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, alu_a);
      end else passes++;
      @(negedge clk);
      #2;
      rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
            $display("FAIL midreset_quiet%0d: rv=%b ready=%b%b, required 000", c, rsp_valid, req0_ready, req1_ready);
         end else passes++;
      end
      @(posedge clk); #1;
      req1_valid = 1'b1;
      exp_d = alu_f(req1_a, req1_b, req1_op);
      @(negedge clk);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, exp_d}) begin
         $display("FAIL midreset_recover: rv=%b id=%b data=%h, required 1 1 %h", rsp_valid, rsp_id, rsp_data, exp_d);
      end else passes++;
   endtask

   // Model: one op in flight at a time, response two cycles after accept, held until consumed.
   task automatic test_random(input int n);
      bit           busy = 1'b0;
      int           age = 0;
      logic         g, exp_id;
      logic [W-1:0] exp_d;
      logic [1:0]   er;
      do_reset();
      for (int i = 0; i < n; i++) begin
         req0_valid = ($urandom_range(0, 2) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         rsp_ready  = ($urandom_range(0, 3) != 0);
         rand_operands();
         @(negedge clk);
         if (!busy) begin
            g  = (req0_valid && req1_valid) ? ~model_lg : req1_valid;
            er = (req0_valid || req1_valid) ? (g ? 2'b01 : 2'b10) : 2'b00;
            checks++;
            if ({req0_ready, req1_ready, rsp_valid} !== {er, 1'b0}) begin
               $display("FAIL rand_idle@%0d: ready=%b%b rv=%b, required %b 0", i, req0_ready, req1_ready, rsp_valid, er);
            end else passes++;
            if (req0_valid || req1_valid) begin
               busy = 1'b1; age = 0; exp_id = g; model_lg = g;
               exp_d = g ? alu_f(req1_a, req1_b, req1_op) : alu_f(req0_a, req0_b, req0_op);
            end
         end else begin
            age++;
            checks++;
            if (age == 1) begin
               if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
                  $display("FAIL rand_exec@%0d: ready=%b%b rv=%b, required 000", i, req0_ready, req1_ready, rsp_valid);
               end else passes++;
            end else begin
               if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data} !== {3'b001, exp_id, exp_d}) begin
                  $display("FAIL rand_resp@%0d: ready=%b%b rv=%b id=%b data=%h, required 001 %b %h", i,
                           req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, exp_id, exp_d);
               end else passes++;
               if (rsp_ready) busy = 1'b0;
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      rand_operands();
      test_reset();
      test_single();
      test_operand_change();
      test_stream(1'b1, 1'b1, "simul");
      test_stream(1'b0, 1'b1, "only1");
      test_backpressure();
      test_reset_mid_exec();
      test_random(400);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 req0_op  input  3  requester 0 ALU control code.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions, widths and meanings as REQ-004..007 for requester 1.
REQ-009 alu_a, alu_b  output  WIDTH each  operands driven to the shared ALU.
REQ-010 alu_ctrl  output  3  control code driven to the shared ALU.
REQ-011 alu_result  input  WIDTH  combinational result from the shared ALU.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_id  output  1  requester index owning the response.
REQ-015 rsp_data  output  WIDTH  registered ALU result.

Function
REQ-016 FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-017 IDLE: no reqN_valid -> stay IDLE; any reqN_valid -> grant one requester, go EXEC next edge.
REQ-018 Grant: one valid -> that one; both valid -> the requester NOT in last_grant (round-robin).
REQ-019 reqN_ready SHALL be combinational, high only in IDLE and only for the granted requester; at most one ready high per cycle.
REQ-020 On the accept edge: latch granted a, b, op into alu_a, alu_b, alu_ctrl; latch grant index into rsp_id and last_grant.
REQ-021 EXEC: lasts exactly one cycle; at its end rsp_data <= alu_result; go RESP.
REQ-022 RESP: rsp_valid=1; rsp_id, rsp_data stable until rsp_valid&&rsp_ready edge, then go IDLE.
REQ-023 rsp_valid SHALL be 0 in IDLE and EXEC.
REQ-024 Latency: accept edge at cycle N -> rsp_valid high in cycle N+2; minimum 3 cycles per operation; no new request accepted before the response handshake completes.
REQ-025 rsp_ready high while in IDLE or EXEC SHALL be ignored.
REQ-026 alu_a, alu_b, alu_ctrl SHALL hold their last latched values outside EXEC; they change only on an accept edge.
REQ-027 reqN_valid deasserted while not granted SHALL be allowed, with no state effect; operand changes after accept SHALL NOT affect the operation in flight.
REQ-028 The block SHALL NOT decode or alter op; the 3-bit code passes through unchanged, so any value is legal.
REQ-029 Response backpressure of any length SHALL be held without data loss.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, last_grant=1 (requester 0 wins first tie), rsp_valid=0, rsp_id=0, rsp_data=0, alu_a=0, alu_b=0, alu_ctrl=0, req0_ready=req1_ready=0.
REQ-031 Reset in EXEC or RESP SHALL abandon the operation; no response is produced after release.
REQ-032 After rst_n rises, first accept SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-033 Single request: req0 a=5, b=3, op=010, ALU models add -> req0_ready 1 cycle, rsp_valid at N+2, rsp_id=0, rsp_data=8.
REQ-034 Simultaneous: req0 and req1 valid from reset, rsp_ready=1 -> grants 0,1,0,1; each rsp_id matches its operands' result.
REQ-035 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_data, rsp_id constant; req0_ready and req1_ready stay 0; completes on rsp_ready=1.
REQ-036 Only req1 valid repeatedly -> req1 granted every operation, no idle grant to req0.
REQ-037 Reset mid-EXEC: assert rst_n=0 -> all outputs 0 at once; after release, rsp_valid stays 0 until a new request is accepted.
REQ-038 Operand change after accept: req0_a changes 5->9 in EXEC -> rsp_data reflects a=5.
